// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
package flash_arb_pkg;

  localparam int unsigned FLASH_ADDR_W = 23;
  localparam int unsigned FLASH_DATA_W = 32;
  localparam logic [3:0]  BYTEEN_ALL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    RESP
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester-side and flash-side Avalon-MM read signals of the flash read arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface flash_read_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = FLASH_ADDR_W,
  parameter int unsigned DATA_W = FLASH_DATA_W
);
  logic              req0_read;
  logic [ADDR_W-1:0] req0_address;
  logic              req0_waitrequest;
  logic              req0_readdatavalid;
  logic [DATA_W-1:0] req0_readdata;

  logic              req1_read;
  logic [ADDR_W-1:0] req1_address;
  logic              req1_waitrequest;
  logic              req1_readdatavalid;
  logic [DATA_W-1:0] req1_readdata;

  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [DATA_W-1:0] flash_mem_readdata;

  modport slave (
    input  req0_read, req0_address, req1_read, req1_address,
    input  flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
    output req0_waitrequest, req0_readdatavalid, req0_readdata,
    output req1_waitrequest, req1_readdatavalid, req1_readdata,
    output flash_mem_read, flash_mem_address, flash_mem_byteenable
  );

  modport master (
    output req0_read, req0_address, req1_read, req1_address,
    output flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
    input  req0_waitrequest, req0_readdatavalid, req0_readdata,
    input  req1_waitrequest, req1_readdatavalid, req1_readdata,
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable
  );

endinterface

// File: rtl/flash_arb_timeout.sv
// Saturating cycle counter; expired is high on the last allowed cycle while enabled.
module flash_arb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic CLK50MHZ,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Count starts at 0 on the first enabled cycle, so this fires on enabled cycle TIMEOUT_CYC.
  assign expired = enable && (cnt_q >= CntLast);

endmodule

// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter for the shared Avalon-MM flash read port, one read outstanding.
// Define FLASH_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (else req0 priority).
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FLASH_ADDR_W,
  parameter int unsigned DATA_W      = FLASH_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                CLK50MHZ,
  input  logic                reset_n,
  flash_read_arbiter_if.slave bus,
  output logic                timeout_err,
  output logic                busy
);
  arb_state_t        state_q;
  req_id_t           grant_q;
  req_id_t           winner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] resp_data;
  logic              valid0_q;
  logic              valid1_q;
  logic              err_q;
  logic              any_req;
  logic              accept;
  logic              expired;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
  req_id_t           rr_last_q;
`endif

  assign any_req   = bus.req0_read | bus.req1_read;
  assign accept    = (state_q == ISSUE) && !bus.flash_mem_waitrequest;
  assign resp_data = bus.flash_mem_readdatavalid ? bus.flash_mem_readdata : '0;

  always_comb begin
`ifdef FLASH_ARB_ROUND_ROBIN_EN
    if (bus.req0_read && bus.req1_read) begin
      winner = ~rr_last_q;
    end else begin
      winner = bus.req1_read;
    end
`else
    winner = ~bus.req0_read;
`endif
  end

  flash_arb_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK50MHZ(CLK50MHZ),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (state_q == WAIT_DATA),
    .expired (expired)
  );

  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      addr_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            addr_q  <= winner ? bus.req1_address : bus.req0_address;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) state_q <= WAIT_DATA;
        end
        WAIT_DATA: begin
          // Valid data on the expiry cycle takes precedence over the timeout.
          if (bus.flash_mem_readdatavalid || expired) begin
            if (grant_q) rdata1_q <= resp_data;
            else         rdata0_q <= resp_data;
            valid0_q <= ~grant_q;
            valid1_q <= grant_q;
            err_q    <= ~bus.flash_mem_readdatavalid;
            state_q  <= RESP;
          end
        end
        RESP: begin
`ifdef FLASH_ARB_ROUND_ROBIN_EN
          rr_last_q <= grant_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.flash_mem_read       = (state_q == ISSUE);
  assign bus.flash_mem_address    = addr_q;
  assign bus.flash_mem_byteenable = (state_q == ISSUE) ? BYTEEN_ALL : 4'b0000;

  assign bus.req0_waitrequest   = !(accept && (grant_q == 1'b0));
  assign bus.req1_waitrequest   = !(accept && (grant_q == 1'b1));
  assign bus.req0_readdatavalid = valid0_q;
  assign bus.req1_readdatavalid = valid1_q;
  assign bus.req0_readdata      = rdata0_q;
  assign bus.req1_readdata      = rdata1_q;

  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed, table-driven bench for flash_read_arbiter with a small Avalon flash responder.
module tb_flash_read_arbiter;

  localparam int unsigned TO_CYC = 8;

  typedef struct {
    bit          id;
    logic [22:0] addr;
    int          stall;
    int          lat;
    logic [31:0] data;
    logic [31:0] exp_data;
    int          exp_dly;
    bit          exp_err;
  } vec_t;

  logic clk;
  logic reset_n;
  logic busy;
  logic timeout_err;

  flash_read_arbiter_if #(.ADDR_W(23), .DATA_W(32)) bus ();

  flash_read_arbiter #(
    .ADDR_W     (23),
    .DATA_W     (32),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK50MHZ   (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  // Flash responder controls
  int          fl_stall = 0;
  int          fl_lat   = 1;
  logic [31:0] fl_data  = '0;
  logic        rdv_m;
  logic [31:0] rdata_m;
  logic        inj_rdv  = 1'b0;
  logic [31:0] inj_data = '0;

  assign bus.flash_mem_readdatavalid = rdv_m | inj_rdv;
  assign bus.flash_mem_readdata      = inj_rdv ? inj_data : rdata_m;

  // Monitor state
  int          cyc     = 0;
  int          acc_n   = 0;
  int          acc_cyc = 0;
  int          v_cyc   = 0;
  int          err_n   = 0;
  int          rd_hi_n = 0;
  int          be_bad  = 0;
  int          v_n[2];
  int          wrl_n[2];
  logic [31:0] v_data[2];
  logic [22:0] acc_addr[$];

  vec_t vecs[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Flash model: inputs for the cycle are set at the falling edge.
  initial begin
    int stall_cnt;
    int pend;
    stall_cnt = 0;
    pend      = 0;
    rdv_m     = 1'b0;
    rdata_m   = '0;
    bus.flash_mem_waitrequest = 1'b1;
    forever begin
      @(negedge clk);
      rdv_m = 1'b0;
      if (!reset_n) begin
        stall_cnt = 0;
        pend      = 0;
        bus.flash_mem_waitrequest = 1'b1;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rdv_m   = 1'b1;
            rdata_m = fl_data;
          end
        end
        if (bus.flash_mem_read) begin
          if (stall_cnt < fl_stall) begin
            bus.flash_mem_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            bus.flash_mem_waitrequest = 1'b0;
            stall_cnt = 0;
            pend      = fl_lat;
          end
        end else begin
          bus.flash_mem_waitrequest = 1'b1;
        end
      end
    end
  end

  initial begin
    v_n[0] = 0; v_n[1] = 0; wrl_n[0] = 0; wrl_n[1] = 0;
    v_data[0] = '0; v_data[1] = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.flash_mem_read) rd_hi_n++;
      if (bus.flash_mem_read && !bus.flash_mem_waitrequest) begin
        acc_n++;
        acc_cyc = cyc;
        acc_addr.push_back(bus.flash_mem_address);
      end
      if (!bus.req0_waitrequest) wrl_n[0]++;
      if (!bus.req1_waitrequest) wrl_n[1]++;
      if (bus.req0_readdatavalid) begin
        v_n[0]++;
        v_data[0] = bus.req0_readdata;
        v_cyc = cyc;
      end
      if (bus.req1_readdatavalid) begin
        v_n[1]++;
        v_data[1] = bus.req1_readdata;
        v_cyc = cyc;
      end
      if (timeout_err) err_n++;
      if (bus.flash_mem_byteenable !== (bus.flash_mem_read ? 4'hF : 4'h0)) be_bad++;
      if ((!bus.req0_waitrequest || !bus.req1_waitrequest) &&
          !(bus.flash_mem_read && !bus.flash_mem_waitrequest)) be_bad++;
      if (!bus.req0_waitrequest && !bus.req1_waitrequest) be_bad++;
    end
  end

  task automatic wait_acc(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = (acc_n >= target);
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      ok = !busy;
    end
    check(name, 64'(ok), 64'(1));
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int  a0, s0, s1, e0, r0, w0, w1;
    bit  ok;
    string t;
    t  = $sformatf("v%0d", n);
    a0 = acc_n; s0 = v_n[0]; s1 = v_n[1]; e0 = err_n; r0 = rd_hi_n;
    w0 = wrl_n[0]; w1 = wrl_n[1];
    fl_stall = v.stall;
    fl_lat   = v.lat;
    fl_data  = v.data;
    if (v.id) begin
      bus.req1_address = v.addr;
      bus.req1_read    = 1'b1;
    end else begin
      bus.req0_address = v.addr;
      bus.req0_read    = 1'b1;
    end
    wait_acc(a0 + 1, {t, "_accept"});
    @(posedge clk);
    #1;
    bus.req0_read = 1'b0;
    bus.req1_read = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (v_n[0] + v_n[1]) > (s0 + s1);
    end
    check({t, "_valid_seen"}, 64'(ok), 64'(1));
    repeat (2) tick();
    if (acc_addr.size() > a0) check({t, "_flash_addr"}, 64'(acc_addr[a0]), 64'(v.addr));
    check({t, "_valid_cnt_own"}, 64'(v_n[v.id] - (v.id ? s1 : s0)), 64'(1));
    check({t, "_valid_cnt_other"}, 64'(v_n[~v.id] - (v.id ? s0 : s1)), 64'(0));
    check({t, "_data"}, 64'(v_data[v.id]), 64'(v.exp_data));
    check({t, "_delay"}, 64'(v_cyc - acc_cyc), 64'(v.exp_dly));
    check({t, "_timeout_err"}, 64'(err_n - e0), 64'(v.exp_err));
    check({t, "_read_cycles"}, 64'(rd_hi_n - r0), 64'(v.stall + 1));
    check({t, "_wreq_low_own"}, 64'(v.id ? wrl_n[1] - w1 : wrl_n[0] - w0), 64'(1));
    check({t, "_wreq_low_other"}, 64'(v.id ? wrl_n[0] - w0 : wrl_n[1] - w1), 64'(0));
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_busy"}, 64'(busy), 64'(0));
    check({t, "_flash_read"}, 64'(bus.flash_mem_read), 64'(0));
    check({t, "_byteenable"}, 64'(bus.flash_mem_byteenable), 64'(0));
    check({t, "_wreq0"}, 64'(bus.req0_waitrequest), 64'(1));
    check({t, "_wreq1"}, 64'(bus.req1_waitrequest), 64'(1));
    check({t, "_valid0"}, 64'(bus.req0_readdatavalid), 64'(0));
    check({t, "_valid1"}, 64'(bus.req1_readdatavalid), 64'(0));
    check({t, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  initial begin
    vec_t v;
    int   a0, s0, s1, e0;
    bit   ok;

    // id, addr, stall, lat, flash data, expected data, valid delay after accept, timeout
    vecs[0] = '{1'b0, 23'h00010,  2, 3, 32'hA5A51234, 32'hA5A51234, 4, 1'b0};
    vecs[1] = '{1'b1, 23'h7FFFF,  0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0};
    vecs[2] = '{1'b0, 23'h7FFFFF, 0, 8, 32'h12345678, 32'h12345678, 9, 1'b0};
    vecs[3] = '{1'b1, 23'h00123,  1, 0, 32'h55AA55AA, 32'h00000000, 9, 1'b1};
    vecs[4] = '{1'b0, 23'h00000,  3, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1'b0};

    bus.req0_read = 1'b0; bus.req0_address = '0;
    bus.req1_read = 1'b0; bus.req1_address = '0;
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
    end

    // Late data two cycles after returning to IDLE from a timeout
    v = '{1'b1, 23'h00042, 0, 0, 32'h0, 32'h0, 9, 1'b1};
    run_vec(v, 5);
    s0 = v_n[0]; s1 = v_n[1]; e0 = err_n;
    @(negedge clk);
    inj_data = 32'hCAFEF00D;
    inj_rdv  = 1'b1;
    @(negedge clk);
    inj_rdv  = 1'b0;
    repeat (4) tick();
    check("late_valid0", 64'(v_n[0] - s0), 64'(0));
    check("late_valid1", 64'(v_n[1] - s1), 64'(0));
    check("late_err", 64'(err_n - e0), 64'(0));
    check("late_busy", 64'(busy), 64'(0));

    // Both requesters held high
    fl_stall = 0; fl_lat = 1; fl_data = 32'h0F0F0F0F;
    a0 = acc_n; s1 = v_n[1];
    bus.req0_address = 23'h00100; bus.req1_address = 23'h7FFFF;
    bus.req0_read = 1'b1; bus.req1_read = 1'b1;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
    wait_acc(a0 + 6, "rr_six_accepts");
    @(posedge clk);
    #1;
    bus.req0_read = 1'b0; bus.req1_read = 1'b0;
    wait_idle("rr_idle");
    for (int k = 0; k < 6; k++) begin
      if (acc_addr.size() > a0 + k)
        check($sformatf("rr_grant%0d", k), 64'(acc_addr[a0 + k]),
              64'(((k % 2) == 1) ? 23'h7FFFF : 23'h00100));
    end
    check("rr_req1_served", 64'(v_n[1] - s1), 64'(3));
`else
    wait_acc(a0 + 10, "prio_ten_accepts");
    check("prio_req1_starved", 64'(v_n[1] - s1), 64'(0));
    @(posedge clk);
    #1;
    bus.req0_read = 1'b0;
    wait_acc(a0 + 11, "prio_req1_accept");
    @(posedge clk);
    #1;
    bus.req1_read = 1'b0;
    wait_idle("prio_idle");
    for (int k = 0; k < 10; k++) begin
      if (acc_addr.size() > a0 + k)
        check($sformatf("prio_grant%0d", k), 64'(acc_addr[a0 + k]), 64'(23'h00100));
    end
    if (acc_addr.size() > a0 + 10)
      check("prio_req1_addr", 64'(acc_addr[a0 + 10]), 64'(23'h7FFFF));
    check("prio_req1_served", 64'(v_n[1] - s1), 64'(1));
`endif

    // Reset while stalled in ISSUE: the read strobe drops at once
    s0 = v_n[0]; s1 = v_n[1]; e0 = err_n;
    fl_stall = 20; fl_lat = 1;
    bus.req0_address = 23'h00555;
    bus.req0_read = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = bus.flash_mem_read;
    end
    check("rst_issue_read_pre", 64'(ok), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_issue");
    bus.req0_read = 1'b0;
    tick();
    reset_n = 1'b1;
    fl_stall = 0;
    tick();

    // Reset while waiting for data
    fl_lat = 0;
    a0 = acc_n;
    bus.req1_address = 23'h00777;
    bus.req1_read = 1'b1;
    wait_acc(a0 + 1, "rst_wd_accept");
    @(posedge clk);
    #1;
    bus.req1_read = 1'b0;
    repeat (3) tick();
    check("rst_wd_busy_pre", 64'(busy), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_wd");
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("rst_no_valid0", 64'(v_n[0] - s0), 64'(0));
    check("rst_no_valid1", 64'(v_n[1] - s1), 64'(0));
    check("rst_no_err", 64'(err_n - e0), 64'(0));

    v = '{1'b1, 23'h00ABC, 0, 2, 32'h600DDA7A, 32'h600DDA7A, 3, 1'b0};
    run_vec(v, 6);

    check("protocol_violations", 64'(be_bad), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single Avalon-MM flash read port between two requesters.
  - Requester 0: audio sample fetcher (playback path, highest priority).
  - Requester 1: secondary reader (volume/peak scan, display fetch).
- Sits between the requesters and the flash controller.
- Issues one read at a time, routes returned data to the granted requester, and recovers from a flash that never returns data.

Parameters:
- ADDR_W, 23, flash word address width.
- DATA_W, 32, flash read data width.
- TIMEOUT_CYC, 255, max CLK50MHZ cycles in WAIT_DATA before forced completion; must be ≥2.

Ports:
- CLK50MHZ  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_read  in  1  requester 0 read request; held until accepted.
- req0_address  in  ADDR_W  requester 0 word address; stable while req0_read is high.
- req0_waitrequest  out  1  high = request not accepted this cycle.
- req0_readdatavalid  out  1  one-cycle pulse; req0_readdata is valid.
- req0_readdata  out  DATA_W  returned word.
- req1_read, req1_address, req1_waitrequest, req1_readdatavalid, req1_readdata: same as requester 0, for requester 1.
- flash_mem_read  out  1  Avalon read strobe to flash.
- flash_mem_address  out  ADDR_W  Avalon address.
- flash_mem_byteenable  out  4  constant 4'b1111 while flash_mem_read is high, else 4'b0000.
- flash_mem_waitrequest  in  1  flash stall.
- flash_mem_readdatavalid  in  1  flash data valid.
- flash_mem_readdata  in  DATA_W  flash data.
- timeout_err  out  1  one-cycle pulse on forced completion.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE, grant=0, rr_last=1.
  - All outputs 0, except reqN_waitrequest=1.
  - Takes effect immediately, including mid-transaction: flash_mem_read drops without waiting for waitrequest.
- States:
  - IDLE:
    - If any reqN_read is high, select a winner.
    - Latch winner id into grant and its address into addr_q.
    - Go to ISSUE.
  - ISSUE:
    - flash_mem_read=1, flash_mem_address=addr_q.
    - If flash_mem_waitrequest=0: req[grant]_waitrequest=0 combinationally this cycle, start timer, go to WAIT_DATA.
    - Otherwise stay in ISSUE.
  - WAIT_DATA:
    - flash_mem_read=0; timer increments each cycle.
    - On flash_mem_readdatavalid=1: register readdata, go to RESP.
    - If the timer reaches TIMEOUT_CYC first: register 0, set an err flag, go to RESP.
    - If readdatavalid and timeout coincide, valid data wins; no error.
  - RESP:
    - req[grant]_readdatavalid=1 for exactly one cycle with the registered data.
    - timeout_err=err flag.
    - Go to IDLE.
- Waitrequest rule: reqN_waitrequest=1 at all times except the ISSUE acceptance cycle for the granted requester.
- Latency, with no flash stall and flash data after L cycles: request seen in IDLE → accepted at cycle +1 → reqN_readdatavalid at cycle +1+L+1.
- Single outstanding read.
  - A readdatavalid arriving in IDLE, ISSUE or RESP is ignored; this covers late data after a timeout.
- Non-granted requester data outputs hold their last value; only its valid pulse is meaningful.
- Selection (default, fixed priority):
  - req0 wins any simultaneous request.
  - req1 is served only when req0_read=0 in IDLE.
- Minimum IDLE dwell is 1 cycle between transactions.

Optional Feature:
- Macro: FLASH_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, the winner is the requester not equal to rr_last.
  - rr_last updates to grant on each RESP.
  - A lone request always wins.
- Undefined: fixed priority to req0 as above; rr_last is not implemented.

Decomposition:
- Package flash_arb_pkg holds:
  - State enum arb_state_t {IDLE, ISSUE, WAIT_DATA, RESP}.
  - Localparams FLASH_ADDR_W=23, FLASH_DATA_W=32, BYTEEN_ALL=4'b1111.
  - Requester id type req_id_t (1 bit).
- One sub-module, flash_arb_timeout:
  - Ports: clear, enable, expired.
  - Saturating counter sized $clog2(TIMEOUT_CYC+1).
  - Async active-low reset.

Test Plan:
1. Single read: req0_read with req0_address=23'h00010; flash_mem_waitrequest high 2 cycles, readdatavalid 3 cycles after acceptance with data 32'hA5A51234 → flash_mem_address=23'h00010 with flash_mem_read high 3 cycles; req0_waitrequest low exactly 1 cycle; req0_readdatavalid 1 cycle later with 32'hA5A51234; req1 outputs show no valid pulse.
2. Simultaneous requests, default build: req0=23'h00100 and req1=23'h7FFFF held high → flash sees 23'h00100 first and 23'h7FFFF only after req0_read drops; continuous req0 starves req1 (check over 10 transactions).
3. FLASH_ARB_ROUND_ROBIN_EN: both requesters held high for 6 transactions → grant order 0,1,0,1,0,1.
4. Timeout, TIMEOUT_CYC=8: no readdatavalid after acceptance → req1_readdatavalid with 32'h00000000 and timeout_err pulse 8–9 cycles after acceptance; a late readdatavalid 2 cycles after return to IDLE produces no pulse.
5. Coincidence: readdatavalid on the exact expiry cycle with 32'h12345678 → data 32'h12345678 delivered, timeout_err stays 0.
6. Reset in WAIT_DATA: pulse reset_n low mid-transaction → busy and flash_mem_read are 0 and reqN_waitrequest is 1 before the next clock edge; no readdatavalid pulse; a subsequent request completes normally.
